// File: rtl/fp_addsub_scheduler.sv
// Round-robin two-port sequencer for the shared combinational FP add/sub unit.
// One operation is in flight at a time; results return with the requester's port and tag.
module fp_addsub_scheduler #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_op_a,
    input  logic [31:0]      req0_op_b,
    input  logic [2:0]       req0_operation,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_op_a,
    input  logic [31:0]      req1_op_b,
    input  logic [2:0]       req1_operation,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      fpu_operand_1,
    output logic [31:0]      fpu_operand_2,
    output logic [2:0]       fpu_operation,
    input  logic [31:0]      fpu_result,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_port,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_result,
    output logic             resp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    state_t             state;
    state_t             state_next;
    logic [3:0]         count;
    logic               last_grant;
    logic               grant_any;
    logic               grant_port;
    logic               op_legal;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [2:0]         sel_op;
    logic [TAG_W-1:0]   sel_tag;

    // last_grant holds the port granted most recently; on a tie the other port wins.
    always_comb begin
        grant_port = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        grant_any  = (state == IDLE) && !flush && rst_n && (req0_valid || req1_valid);
        req0_ready = grant_any && !grant_port;
        req1_ready = grant_any && grant_port;
        sel_a      = grant_port ? req1_op_a      : req0_op_a;
        sel_b      = grant_port ? req1_op_b      : req0_op_b;
        sel_op     = grant_port ? req1_operation : req0_operation;
        sel_tag    = grant_port ? req1_tag       : req0_tag;
        op_legal   = (sel_op[2:1] == 2'b00);
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (grant_any) state_next = op_legal ? EXEC : DONE;
                EXEC:    if (count == 4'd0) state_next = DONE;
                DONE:    if (resp_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // busy and resp_valid are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != IDLE);
            resp_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= 4'd0;
            last_grant    <= 1'b1;
            fpu_operand_1 <= 32'h0;
            fpu_operand_2 <= 32'h0;
            fpu_operation <= 3'b000;
            resp_port     <= 1'b0;
            resp_tag      <= '0;
            resp_result   <= 32'h0;
            resp_err      <= 1'b0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_port;
                        resp_port  <= grant_port;
                        resp_tag   <= sel_tag;
                        // Illegal codes bypass the FP unit, leaving its operands untouched.
                        if (op_legal) begin
                            fpu_operand_1 <= sel_a;
                            fpu_operand_2 <= sel_b;
                            fpu_operation <= sel_op;
                            count         <= COUNT_LOAD;
                            resp_err      <= 1'b0;
                        end else begin
                            resp_err      <= 1'b1;
                            resp_result   <= 32'h0;
                        end
                    end
                end
                EXEC: begin
                    if (count == 4'd0) begin
                        resp_result <= fpu_result;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Self-checking bench for fp_addsub_scheduler: directed vectors, corner sequences
// and a randomized run against a timestamp-based reference model.
module tb_fp_addsub_scheduler;

    localparam int LAT = 2;
    localparam int TW  = 4;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [31:0]   req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic [2:0]    req0_operation, req1_operation;
    logic [TW-1:0] req0_tag, req1_tag;
    logic [31:0]   fpu_operand_1, fpu_operand_2;
    logic [2:0]    fpu_operation;
    logic [31:0]   fpu_result;
    logic          flush;
    logic          resp_valid, resp_ready, resp_port, resp_err, busy;
    logic [TW-1:0] resp_tag;
    logic [31:0]   resp_result;

    int n_checks = 0;
    int n_fails  = 0;
    int age      = 15;

    typedef struct {
        logic          port;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [2:0]    op;
        logic [TW-1:0] tag;
        logic [31:0]   exp_result;
        logic          exp_err;
    } vec_t;

    vec_t vecs[5];

    fp_addsub_scheduler #(.LATENCY(LAT), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op_a(req0_op_a),
        .req0_op_b(req0_op_b), .req0_operation(req0_operation), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op_a(req1_op_a),
        .req1_op_b(req1_op_b), .req1_operation(req1_operation), .req1_tag(req1_tag),
        .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
        .fpu_operation(fpu_operation), .fpu_result(fpu_result), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_port(resp_port),
        .resp_tag(resp_tag), .resp_result(resp_result), .resp_err(resp_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in FP unit: known float cases from the test plan, integer arithmetic otherwise.
    function automatic logic [31:0] fake_fpu(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
        if (op == 3'b000 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 3'b001 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        return (op == 3'b001) ? a - b : a + b;
    endfunction

    // The unit's output is garbage until its operands have settled for LAT cycles.
    always @(posedge clk) begin
        if ((req0_valid && req0_ready && req0_operation <= 3'b001) ||
            (req1_valid && req1_ready && req1_operation <= 3'b001))
            age <= 0;
        else if (age < 15)
            age <= age + 1;
    end

    always_comb begin
        fpu_result = 32'hDEADBEEF;
        if (age >= LAT - 1) fpu_result = fake_fpu(fpu_operand_1, fpu_operand_2, fpu_operation);
    end

    // Requester protocol: a pending request stays valid with stable fields until ready.
    logic        hold0, hold1;
    logic [70:0] snap0, snap1;
    always @(posedge clk) begin
        if (rst_n && hold0)
            assert (req0_valid && snap0 == {req0_op_a, req0_op_b, req0_operation, req0_tag})
            else $error("[TB] requester 0 changed its request before ready");
        if (rst_n && hold1)
            assert (req1_valid && snap1 == {req1_op_a, req1_op_b, req1_operation, req1_tag})
            else $error("[TB] requester 1 changed its request before ready");
        hold0 <= rst_n && req0_valid && !req0_ready;
        hold1 <= rst_n && req1_valid && !req1_ready;
        snap0 <= {req0_op_a, req0_op_b, req0_operation, req0_tag};
        snap1 <= {req1_op_a, req1_op_b, req1_operation, req1_tag};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic idleInputs();
        req0_valid = 0; req1_valid = 0; flush = 0; resp_ready = 0;
    endtask

    task automatic setReq(input logic port, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [TW-1:0] tag);
        if (port) begin
            req1_valid = 1; req1_op_a = a; req1_op_b = b; req1_operation = op; req1_tag = tag;
        end else begin
            req0_valid = 1; req0_op_a = a; req0_op_b = b; req0_operation = op; req0_tag = tag;
        end
    endtask

    task automatic clrReq(input logic port);
        if (port) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic waitResp(input string name, input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk); #1;
            seen = resp_valid;
        end
        if (!seen) timeoutFail(name);
    endtask

    task automatic collectResp(input string name, input logic port, input logic [TW-1:0] tag,
                               input logic [31:0] result, input logic err);
        waitResp(name, 20);
        checkOutput({name, "_port"}, 32'(resp_port), 32'(port));
        checkOutput({name, "_tag"}, 32'(resp_tag), 32'(tag));
        checkOutput({name, "_result"}, resp_result, result);
        checkOutput({name, "_err"}, 32'(resp_err), 32'(err));
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 0;
        idleInputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    // One transaction with exact cycle-by-cycle timing checks.
    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] p1, p2;
        logic [2:0]  pop;
        int          lat;
        @(negedge clk);
        p1 = fpu_operand_1; p2 = fpu_operand_2; pop = fpu_operation;
        setReq(v.port, v.a, v.b, v.op, v.tag);
        #1;
        checkOutput($sformatf("vec%0d_ready", idx), 32'(v.port ? req1_ready : req0_ready), 32'd1);
        @(negedge clk);
        clrReq(v.port);
        #1;
        lat = v.exp_err ? 1 : LAT + 1;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin @(negedge clk); #1; end
            checkOutput($sformatf("vec%0d_valid_c%0d", idx, k), 32'(resp_valid), 32'(k == lat));
            checkOutput($sformatf("vec%0d_busy_c%0d", idx, k), 32'(busy), 32'd1);
            if (k == 1) begin
                checkOutput($sformatf("vec%0d_fpu1", idx), fpu_operand_1, v.exp_err ? p1 : v.a);
                checkOutput($sformatf("vec%0d_fpu2", idx), fpu_operand_2, v.exp_err ? p2 : v.b);
                checkOutput($sformatf("vec%0d_fpuop", idx), 32'(fpu_operation),
                            32'(v.exp_err ? pop : v.op));
            end
        end
        checkOutput($sformatf("vec%0d_port", idx), 32'(resp_port), 32'(v.port));
        checkOutput($sformatf("vec%0d_tag", idx), 32'(resp_tag), 32'(v.tag));
        checkOutput($sformatf("vec%0d_result", idx), resp_result, v.exp_result);
        checkOutput($sformatf("vec%0d_err", idx), 32'(resp_err), 32'(v.exp_err));
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        #1;
        checkOutput($sformatf("vec%0d_after_valid", idx), 32'(resp_valid), 32'd0);
        checkOutput($sformatf("vec%0d_after_busy", idx), 32'(busy), 32'd0);
    endtask

    function automatic logic [2:0] randOp();
        int r = $urandom_range(0, 9);
        if (r < 4) return 3'b000;
        if (r < 8) return 3'b001;
        return 3'($urandom_range(2, 7));
    endfunction

    initial begin
        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 3'b000, 4'd5,  32'h40400000, 1'b0};
        vecs[1] = '{1, 32'h40400000, 32'h3F800000, 3'b001, 4'd7,  32'h40000000, 1'b0};
        vecs[2] = '{1, 32'h11112222, 32'h33334444, 3'b010, 4'd9,  32'h00000000, 1'b1};
        vecs[3] = '{0, 32'h12345678, 32'h00001111, 3'b000, 4'd3,  32'h12346789, 1'b0};
        vecs[4] = '{0, 32'h55555555, 32'hAAAAAAAA, 3'b111, 4'd15, 32'h00000000, 1'b1};

        req0_op_a = 0; req0_op_b = 0; req0_operation = 0; req0_tag = 0;
        req1_op_a = 0; req1_op_b = 0; req1_operation = 0; req1_tag = 0;
        rst_n = 0;
        idleInputs();
        req0_valid = 1;
        @(negedge clk); #1;
        checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_fpu1", fpu_operand_1, 32'd0);
        checkOutput("rst_result", resp_result, 32'd0);
        @(negedge clk);
        req0_valid = 0;
        rst_n = 1;

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Backpressure: response held while resp_ready stays low.
        @(negedge clk);
        setReq(0, 32'h3F800000, 32'h40000000, 3'b000, 4'd6);
        #1;
        checkOutput("bp_grant", 32'(req0_ready), 32'd1);
        @(negedge clk);
        clrReq(0);
        waitResp("bp_wait", 10);
        setReq(1, 32'h40400000, 32'h3F800000, 3'b001, 4'd11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checkOutput("bp_valid", 32'(resp_valid), 32'd1);
            checkOutput("bp_tag", 32'(resp_tag), 32'd6);
            checkOutput("bp_result", resp_result, 32'h40400000);
            checkOutput("bp_ready0", 32'(req0_ready), 32'd0);
            checkOutput("bp_ready1", 32'(req1_ready), 32'd0);
            checkOutput("bp_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        #1;
        checkOutput("bp_release_valid", 32'(resp_valid), 32'd0);
        checkOutput("bp_release_busy", 32'(busy), 32'd0);
        checkOutput("bp_new_grant", 32'(req1_ready), 32'd1);
        @(negedge clk);
        clrReq(1);
        collectResp("bp_second", 1, 4'd11, 32'h40000000, 0);

        // Flush during EXEC drops the operation.
        @(negedge clk);
        setReq(0, 32'h3F800000, 32'h40000000, 3'b000, 4'd2);
        #1;
        checkOutput("flx_grant", 32'(req0_ready), 32'd1);
        @(negedge clk);
        clrReq(0);
        flush = 1;
        @(negedge clk);
        flush = 0;
        #1;
        checkOutput("flx_busy", 32'(busy), 32'd0);
        for (int i = 0; i < LAT + 2; i++) begin
            checkOutput("flx_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk); #1;
        end

        // Flush in IDLE blocks the grant for one cycle only.
        setReq(0, 32'h40400000, 32'h3F800000, 3'b001, 4'd13);
        flush = 1;
        #1;
        checkOutput("fli_ready0", 32'(req0_ready), 32'd0);
        checkOutput("fli_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        flush = 0;
        #1;
        checkOutput("fli_grant", 32'(req0_ready), 32'd1);
        @(negedge clk);
        clrReq(0);
        collectResp("fli_resp", 0, 4'd13, 32'h40000000, 0);

        // Asynchronous reset in the middle of EXEC.
        @(negedge clk);
        setReq(0, 32'h3F800000, 32'h40000000, 3'b000, 4'd4);
        #1;
        checkOutput("rmo_grant", 32'(req0_ready), 32'd1);
        @(negedge clk);
        clrReq(0);
        #2;
        rst_n = 0;
        #1;
        checkOutput("rmo_fpu1", fpu_operand_1, 32'd0);
        checkOutput("rmo_fpu2", fpu_operand_2, 32'd0);
        checkOutput("rmo_fpuop", 32'(fpu_operation), 32'd0);
        checkOutput("rmo_busy", 32'(busy), 32'd0);
        checkOutput("rmo_tag", 32'(resp_tag), 32'd0);
        checkOutput("rmo_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Contention: alternating grants, first tie after reset goes to port 0.
        setReq(0, 32'h40400000, 32'h3F800000, 3'b001, 4'd1);
        setReq(1, 32'h40400000, 32'h3F800000, 3'b001, 4'd2);
        resp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bit got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                got = req0_ready || req1_ready;
            end
            if (!got) timeoutFail("cont_grant_wait");
            checkOutput($sformatf("cont_grant%0d", i), {30'd0, req1_ready, req0_ready},
                        (i % 2) ? 32'd2 : 32'd1);
            waitResp("cont_resp_wait", 10);
            checkOutput($sformatf("cont_port%0d", i), 32'(resp_port), 32'(i % 2));
            checkOutput($sformatf("cont_tag%0d", i), 32'(resp_tag), (i % 2) ? 32'd2 : 32'd1);
            checkOutput($sformatf("cont_result%0d", i), resp_result, 32'h40000000);
            @(negedge clk);
        end

        doReset();

        // Randomized run against a timestamp reference model.
        begin
            logic          v0, v1, fl, rr, win, grant, exp_valid, legal;
            logic [31:0]   a0, b0, a1, b1;
            logic [2:0]    o0, o1;
            logic [TW-1:0] t0, t1;
            logic          inflight, last, e_port, e_err;
            logic [TW-1:0] e_tag;
            logic [31:0]   e_result;
            int            due, cyc;
            v0 = 0; v1 = 0; inflight = 0; last = 1; due = 0;
            e_port = 0; e_err = 0; e_tag = 0; e_result = 0;
            a0 = 0; b0 = 0; a1 = 0; b1 = 0; o0 = 0; o1 = 0; t0 = 0; t1 = 0;
            for (cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                if (!v0 && $urandom_range(0, 2) == 0) begin
                    v0 = 1; a0 = $urandom; b0 = $urandom; o0 = randOp(); t0 = TW'($urandom);
                end
                if (!v1 && $urandom_range(0, 2) == 0) begin
                    v1 = 1; a1 = $urandom; b1 = $urandom; o1 = randOp(); t1 = TW'($urandom);
                end
                fl = ($urandom_range(0, 24) == 0);
                rr = ($urandom_range(0, 3) != 0);
                req0_valid = v0; req0_op_a = a0; req0_op_b = b0; req0_operation = o0; req0_tag = t0;
                req1_valid = v1; req1_op_a = a1; req1_op_b = b1; req1_operation = o1; req1_tag = t1;
                flush = fl;
                resp_ready = rr;
                #1;
                exp_valid = inflight && (cyc >= due);
                grant = !inflight && !fl && (v0 || v1);
                win = (v0 && v1) ? !last : v1;
                checkOutput("rnd_ready0", 32'(req0_ready), 32'(grant && !win));
                checkOutput("rnd_ready1", 32'(req1_ready), 32'(grant && win));
                checkOutput("rnd_busy", 32'(busy), 32'(inflight));
                checkOutput("rnd_resp_valid", 32'(resp_valid), 32'(exp_valid));
                if (exp_valid) begin
                    checkOutput("rnd_port", 32'(resp_port), 32'(e_port));
                    checkOutput("rnd_tag", 32'(resp_tag), 32'(e_tag));
                    checkOutput("rnd_result", resp_result, e_result);
                    checkOutput("rnd_err", 32'(resp_err), 32'(e_err));
                end
                if (fl) begin
                    inflight = 0;
                end else if (grant) begin
                    legal    = win ? (o1 <= 3'b001) : (o0 <= 3'b001);
                    inflight = 1;
                    due      = cyc + (legal ? LAT + 1 : 1);
                    e_port   = win;
                    e_tag    = win ? t1 : t0;
                    e_err    = !legal;
                    e_result = !legal ? 32'h0 : (win ? fake_fpu(a1, b1, o1) : fake_fpu(a0, b0, o0));
                    last     = win;
                    if (win) v1 = 0; else v0 = 0;
                end else if (exp_valid && rr) begin
                    inflight = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
